iq_age_select: RTL and testbench

- Select stage directly downstream of the issue queue wakeup array.
- Each cycle it picks up to two ready entries, one per execution port (port 0, port 1), choosing the oldest first by dispatch order.
- Grants are registered; the one-hot grant vectors drive payload RAM read and dst-tag broadcast.
- Tracks its own per-entry occupancy, so a granted or killed entry can never be selected twice.

---
 rtl/iq_age_select.sv | 179 +++++++++++++++++
 tb/tb_iq_age_select.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/iq_age_select.sv
`default_nettype none
// ============================================================================
//  Module   : iq_age_select
//  Brief    : Dual-port oldest-first select stage behind the issue queue
//             wakeup array. Tracks its own entry occupancy, so an entry that
//             has been granted or killed can never be selected again.
//             Grants are registered.
//  Option   : IQ_AGE_MATRIX_EN
//               defined   - oldest-first selection from a dispatch-age matrix
//               undefined - lowest-index selection, no age matrix
//  Revision : 1.0 - initial release
// ============================================================================
module iq_age_select #(
    parameter int IQ_ENT_NUM = 16,
    parameter int IQ_ENT_SEL = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  alloc_en_1,
    input  logic [IQ_ENT_SEL-1:0] alloc_idx_1,
    input  logic                  alloc_en_2,
    input  logic [IQ_ENT_SEL-1:0] alloc_idx_2,
    input  logic [IQ_ENT_NUM-1:0] req_p0,
    input  logic [IQ_ENT_NUM-1:0] req_p1,
    input  logic [IQ_ENT_NUM-1:0] kill_vec,
    input  logic                  issue_stall,
    output logic                  grant_vld_0,
    output logic [IQ_ENT_SEL-1:0] grant_idx_0,
    output logic                  grant_vld_1,
    output logic [IQ_ENT_SEL-1:0] grant_idx_1,
    output logic [IQ_ENT_NUM-1:0] grant_vec,
    output logic [IQ_ENT_NUM-1:0] occ_vec
);

    localparam logic [IQ_ENT_NUM-1:0] c_one = {{(IQ_ENT_NUM-1){1'b0}}, 1'b1};

    logic [IQ_ENT_NUM-1:0] occ_q, occ_d;
    logic                  grant_vld_0_q, grant_vld_0_d;
    logic                  grant_vld_1_q, grant_vld_1_d;
    logic [IQ_ENT_SEL-1:0] grant_idx_0_q, grant_idx_0_d;
    logic [IQ_ENT_SEL-1:0] grant_idx_1_q, grant_idx_1_d;

    logic [IQ_ENT_NUM-1:0] w_eff_p0, w_eff_p1;
    logic [IQ_ENT_NUM-1:0] w_win_p0, w_win_p1;
    logic [IQ_ENT_SEL-1:0] w_win_idx_0, w_win_idx_1;
    logic [IQ_ENT_NUM-1:0] w_granted, w_survivors, w_alloc_oh;

    // Effective requests: only live, unkilled entries; dual requesters go to port 0 only.
    always_comb begin
        w_eff_p0 = req_p0 & occ_q & ~kill_vec;
        w_eff_p1 = req_p1 & ~req_p0 & occ_q & ~kill_vec;
    end

`ifdef IQ_AGE_MATRIX_EN
    // age_q[i][j] = 1 : entry i was dispatched before entry j
    logic [IQ_ENT_NUM-1:0] age_q [IQ_ENT_NUM];
    logic [IQ_ENT_NUM-1:0] age_d [IQ_ENT_NUM];
    logic [IQ_ENT_NUM-1:0] w_age_col [IQ_ENT_NUM];

    // Transpose so each entry sees the set of entries older than itself.
    always_comb begin
        for (int i = 0; i < IQ_ENT_NUM; i++) begin
            for (int j = 0; j < IQ_ENT_NUM; j++) begin
                w_age_col[i][j] = age_q[j][i];
            end
        end
    end

    // Winner is the requester that no other requester is older than.
    always_comb begin
        for (int i = 0; i < IQ_ENT_NUM; i++) begin
            w_win_p0[i] = w_eff_p0[i] & ~(|(w_eff_p0 & w_age_col[i]));
            w_win_p1[i] = w_eff_p1[i] & ~(|(w_eff_p1 & w_age_col[i]));
        end
    end

    // New entries are younger than every surviving entry; slot 2 is younger than slot 1.
    always_comb begin
        for (int i = 0; i < IQ_ENT_NUM; i++) begin
            age_d[i] = age_q[i];
        end
        if (alloc_en_1) begin
            for (int j = 0; j < IQ_ENT_NUM; j++) begin
                age_d[j][alloc_idx_1] = w_survivors[j];
            end
            age_d[alloc_idx_1] = '0;
        end
        if (alloc_en_2) begin
            for (int j = 0; j < IQ_ENT_NUM; j++) begin
                age_d[j][alloc_idx_2] = w_survivors[j];
            end
            age_d[alloc_idx_2] = '0;
            if (alloc_en_1) begin
                age_d[alloc_idx_1][alloc_idx_2] = 1'b1;
            end
        end
    end

    // Age matrix register.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < IQ_ENT_NUM; i++) begin
                age_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < IQ_ENT_NUM; i++) begin
                age_q[i] <= age_d[i];
            end
        end
    end
`else
    // Lowest-index requester wins: isolate the least significant set bit.
    always_comb begin
        w_win_p0 = w_eff_p0 & (~w_eff_p0 + c_one);
        w_win_p1 = w_eff_p1 & (~w_eff_p1 + c_one);
    end
`endif

    // One-hot winner to binary index.
    always_comb begin
        w_win_idx_0 = '0;
        w_win_idx_1 = '0;
        for (int i = 0; i < IQ_ENT_NUM; i++) begin
            if (w_win_p0[i]) w_win_idx_0 = w_win_idx_0 | IQ_ENT_SEL'(i);
            if (w_win_p1[i]) w_win_idx_1 = w_win_idx_1 | IQ_ENT_SEL'(i);
        end
    end

    // Next occupancy and grants: allocation beats grant, kill beats allocation.
    always_comb begin
        w_granted   = issue_stall ? '0 : (w_win_p0 | w_win_p1);
        w_survivors = occ_q & ~kill_vec & ~w_granted;
        w_alloc_oh  = (alloc_en_1 ? (c_one << alloc_idx_1) : '0)
                    | (alloc_en_2 ? (c_one << alloc_idx_2) : '0);
        occ_d       = ((occ_q & ~w_granted) | w_alloc_oh) & ~kill_vec;

        grant_vld_0_d = ~issue_stall & (|w_eff_p0);
        grant_vld_1_d = ~issue_stall & (|w_eff_p1);
        grant_idx_0_d = grant_vld_0_d ? w_win_idx_0 : grant_idx_0_q;
        grant_idx_1_d = grant_vld_1_d ? w_win_idx_1 : grant_idx_1_q;
    end

    // Occupancy and grant registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            occ_q         <= '0;
            grant_vld_0_q <= 1'b0;
            grant_vld_1_q <= 1'b0;
            grant_idx_0_q <= '0;
            grant_idx_1_q <= '0;
        end else begin
            occ_q         <= occ_d;
            grant_vld_0_q <= grant_vld_0_d;
            grant_vld_1_q <= grant_vld_1_d;
            grant_idx_0_q <= grant_idx_0_d;
            grant_idx_1_q <= grant_idx_1_d;
        end
    end

    assign grant_vld_0 = grant_vld_0_q;
    assign grant_vld_1 = grant_vld_1_q;
    assign grant_idx_0 = grant_idx_0_q;
    assign grant_idx_1 = grant_idx_1_q;
    assign occ_vec     = occ_q;
    assign grant_vec   = ({IQ_ENT_NUM{grant_vld_0_q}} & (c_one << grant_idx_0_q))
                       | ({IQ_ENT_NUM{grant_vld_1_q}} & (c_one << grant_idx_1_q));

    // Both dispatch slots must never target the same entry.
    a_alloc_same_idx: assert property (@(posedge clk) disable iff (reset)
        !(alloc_en_1 && alloc_en_2 && (alloc_idx_1 == alloc_idx_2)));

    // Allocation must target a free entry.
    a_alloc_occ_1: assert property (@(posedge clk) disable iff (reset)
        !(alloc_en_1 && occ_q[alloc_idx_1]));
    a_alloc_occ_2: assert property (@(posedge clk) disable iff (reset)
        !(alloc_en_2 && occ_q[alloc_idx_2]));

endmodule
`default_nettype wire

// File: tb/tb_iq_age_select.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_iq_age_select
//  Brief    : Self-checking bench for iq_age_select: directed vector table,
//             hand-written multi-cycle sequences and randomized traffic
//             against a dispatch-sequence-number reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_iq_age_select;

    localparam int N = 16;
    localparam int S = 4;

`ifdef IQ_AGE_MATRIX_EN
    localparam bit AGE = 1'b1;
`else
    localparam bit AGE = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic         alloc_en_1, alloc_en_2;
    logic [S-1:0] alloc_idx_1, alloc_idx_2;
    logic [N-1:0] req_p0, req_p1, kill_vec;
    logic         issue_stall;
    logic         grant_vld_0, grant_vld_1;
    logic [S-1:0] grant_idx_0, grant_idx_1;
    logic [N-1:0] grant_vec, occ_vec;

    iq_age_select #(.IQ_ENT_NUM(N), .IQ_ENT_SEL(S)) dut (
        .clk(clk), .reset(reset),
        .alloc_en_1(alloc_en_1), .alloc_idx_1(alloc_idx_1),
        .alloc_en_2(alloc_en_2), .alloc_idx_2(alloc_idx_2),
        .req_p0(req_p0), .req_p1(req_p1), .kill_vec(kill_vec),
        .issue_stall(issue_stall),
        .grant_vld_0(grant_vld_0), .grant_idx_0(grant_idx_0),
        .grant_vld_1(grant_vld_1), .grant_idx_1(grant_idx_1),
        .grant_vec(grant_vec), .occ_vec(occ_vec)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: occupancy plus a dispatch sequence number per entry.
    bit          m_occ [N];
    int unsigned m_seq [N];
    int unsigned m_ctr;
    bit          m_v0, m_v1;
    int          m_i0, m_i1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int pick(input logic [N-1:0] eff);
        int best = -1;
        for (int i = 0; i < N; i++) begin
            if (eff[i]) begin
                if (best < 0) best = i;
                else if (AGE && (m_seq[i] < m_seq[best])) best = i;
            end
        end
        return best;
    endfunction

    function automatic logic [N-1:0] m_occ_vec();
        logic [N-1:0] v;
        for (int i = 0; i < N; i++) v[i] = m_occ[i];
        return v;
    endfunction

    function automatic logic [N-1:0] m_grant_vec();
        logic [N-1:0] one = 1;
        logic [N-1:0] v   = '0;
        if (m_v0) v = v | (one << m_i0);
        if (m_v1) v = v | (one << m_i1);
        return v;
    endfunction

    task automatic model_step();
        logic [N-1:0] occv, e0, e1;
        int w0, w1;
        if (reset) begin
            for (int i = 0; i < N; i++) m_occ[i] = 1'b0;
            m_v0 = 0; m_v1 = 0; m_i0 = 0; m_i1 = 0;
            return;
        end
        occv = m_occ_vec();
        e0 = req_p0 & occv & ~kill_vec;
        e1 = req_p1 & ~req_p0 & occv & ~kill_vec;
        w0 = pick(e0);
        w1 = pick(e1);
        if (issue_stall) begin
            m_v0 = 0; m_v1 = 0;
        end else begin
            m_v0 = (w0 >= 0);
            m_v1 = (w1 >= 0);
            if (w0 >= 0) begin m_i0 = w0; m_occ[w0] = 1'b0; end
            if (w1 >= 0) begin m_i1 = w1; m_occ[w1] = 1'b0; end
        end
        if (alloc_en_1) begin m_occ[alloc_idx_1] = 1'b1; m_seq[alloc_idx_1] = m_ctr; m_ctr++; end
        if (alloc_en_2) begin m_occ[alloc_idx_2] = 1'b1; m_seq[alloc_idx_2] = m_ctr; m_ctr++; end
        for (int i = 0; i < N; i++) if (kill_vec[i]) m_occ[i] = 1'b0;
    endtask

    task automatic drive(input bit a1e, input int a1, input bit a2e, input int a2,
                         input logic [N-1:0] r0, input logic [N-1:0] r1,
                         input logic [N-1:0] k, input bit st);
        alloc_en_1 = a1e; alloc_idx_1 = S'(a1);
        alloc_en_2 = a2e; alloc_idx_2 = S'(a2);
        req_p0 = r0; req_p1 = r1; kill_vec = k; issue_stall = st;
    endtask

    // One clock: update the model with the inputs present at the edge, then compare.
    task automatic step(input string tag);
        @(posedge clk);
        model_step();
        #1;
        chk({tag, "_vld0"}, grant_vld_0, m_v0);
        chk({tag, "_idx0"}, grant_idx_0, m_i0);
        chk({tag, "_vld1"}, grant_vld_1, m_v1);
        chk({tag, "_idx1"}, grant_idx_1, m_i1);
        chk({tag, "_gvec"}, grant_vec, m_grant_vec());
        chk({tag, "_occ"},  occ_vec, m_occ_vec());
    endtask

    function automatic int pick_free(input int avoid);
        int st = $urandom_range(0, N-1);
        for (int k = 0; k < N; k++) begin
            int i = (st + k) % N;
            if (!m_occ[i] && i != avoid) return i;
        end
        return -1;
    endfunction

    typedef struct {
        bit           a1e; int a1; bit a2e; int a2;
        logic [N-1:0] r0, r1, kill; bit stall;
        bit           v0; int i0; bit v1; int i1;
        logic [N-1:0] gvec, occ;
    } vec_t;

    vec_t tbl [20];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        m_ctr = 0;
        //           a1e a1 a2e a2  req_p0    req_p1    kill      st  v0 i0 v1 i1 gvec      occ
        tbl[0]  = '{1, 3, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 0, 0, 16'h0000, 16'h0008};
        tbl[1]  = '{1, 7, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 0, 0, 16'h0000, 16'h0088};
        tbl[2]  = '{1, 9, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 0, 0, 16'h0000, 16'h0288};
        tbl[3]  = '{0, 0, 0, 0, 16'h0200, 16'h0088, 16'h0000, 0, 1, 9, 1, 3, 16'h0208, 16'h0080};
        tbl[4]  = '{0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 9, 0, 3, 16'h0000, 16'h0080};
        tbl[5]  = '{0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0080, 0, 0, 9, 0, 3, 16'h0000, 16'h0000};
        tbl[6]  = '{1, 4, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 9, 0, 3, 16'h0000, 16'h0010};
        tbl[7]  = '{0, 0, 0, 0, 16'h0010, 16'h0010, 16'h0000, 0, 1, 4, 0, 3, 16'h0010, 16'h0000};
        tbl[8]  = '{0, 0, 0, 0, 16'h0010, 16'h0010, 16'h0000, 0, 0, 4, 0, 3, 16'h0000, 16'h0000};
        tbl[9]  = '{0, 0, 0, 0, 16'h0010, 16'h0010, 16'h0000, 0, 0, 4, 0, 3, 16'h0000, 16'h0000};
        tbl[10] = '{0, 0, 0, 0, 16'h0010, 16'h0010, 16'h0000, 0, 0, 4, 0, 3, 16'h0000, 16'h0000};
        tbl[11] = '{1, 1, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 4, 0, 3, 16'h0000, 16'h0002};
        tbl[12] = '{1, 6, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 4, 0, 3, 16'h0000, 16'h0042};
        tbl[13] = '{0, 0, 0, 0, 16'h0042, 16'h0000, 16'h0002, 0, 1, 6, 0, 3, 16'h0040, 16'h0000};
        tbl[14] = '{1, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 6, 0, 3, 16'h0000, 16'h0001};
        tbl[15] = '{0, 0, 0, 0, 16'h0001, 16'h0000, 16'h0000, 1, 0, 6, 0, 3, 16'h0000, 16'h0001};
        tbl[16] = '{0, 0, 0, 0, 16'h0001, 16'h0000, 16'h0000, 1, 0, 6, 0, 3, 16'h0000, 16'h0001};
        tbl[17] = '{0, 0, 0, 0, 16'h0001, 16'h0000, 16'h0000, 0, 1, 0, 0, 3, 16'h0001, 16'h0000};
        tbl[18] = '{1, 8, 1, 10, 16'h0000, 16'h0000, 16'h0100, 0, 0, 0, 0, 3, 16'h0000, 16'h0400};
        tbl[19] = '{0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0400, 0, 0, 0, 0, 3, 16'h0000, 16'h0000};

        // Reset state
        reset = 1'b1;
        drive(0, 0, 0, 0, '0, '0, '0, 0);
        step("rst0");
        step("rst1");
        reset = 1'b0;
        chk("reset_occ",  occ_vec, 0);
        chk("reset_gvec", grant_vec, 0);
        chk("reset_vld",  {grant_vld_0, grant_vld_1}, 0);
        chk("reset_idx",  {grant_idx_0, grant_idx_1}, 0);

        // Directed vector table
        for (int r = 0; r < 20; r++) begin
            drive(tbl[r].a1e, tbl[r].a1, tbl[r].a2e, tbl[r].a2,
                  tbl[r].r0, tbl[r].r1, tbl[r].kill, tbl[r].stall);
            step($sformatf("tbl%0d", r));
            chk($sformatf("tbl%0d_exp_vld0", r), grant_vld_0, tbl[r].v0);
            chk($sformatf("tbl%0d_exp_idx0", r), grant_idx_0, tbl[r].i0);
            chk($sformatf("tbl%0d_exp_vld1", r), grant_vld_1, tbl[r].v1);
            chk($sformatf("tbl%0d_exp_idx1", r), grant_idx_1, tbl[r].i1);
            chk($sformatf("tbl%0d_exp_gvec", r), grant_vec, tbl[r].gvec);
            chk($sformatf("tbl%0d_exp_occ",  r), occ_vec, tbl[r].occ);
        end

        // Dual allocation 5 then 2 (2 is younger), both request port 0
        drive(1, 5, 1, 2, '0, '0, '0, 0);
        step("dual_alloc");
        chk("dual_alloc_occ", occ_vec, 16'h0024);
        drive(0, 0, 0, 0, 16'h0024, '0, '0, 0);
        step("dual_g1");
        chk("dual_g1_vld0", grant_vld_0, 1);
        chk("dual_g1_idx0", grant_idx_0, AGE ? 5 : 2);
        chk("dual_g1_occ",  occ_vec, AGE ? 16'h0004 : 16'h0020);
        step("dual_g2");
        chk("dual_g2_vld0", grant_vld_0, 1);
        chk("dual_g2_idx0", grant_idx_0, AGE ? 2 : 5);
        chk("dual_g2_occ",  occ_vec, 0);

        // Fill 15..0, drain on port 1, reset mid-drain
        for (int k = 0; k < N; k++) begin
            drive(1, N-1-k, 0, 0, '0, '0, '0, 0);
            step("fill");
        end
        chk("fill_occ", occ_vec, 16'hFFFF);
        for (int k = 0; k < 8; k++) begin
            drive(0, 0, 0, 0, '0, 16'hFFFF, '0, 0);
            step("drain");
            chk($sformatf("drain%0d_vld1", k), grant_vld_1, 1);
            chk($sformatf("drain%0d_idx1", k), grant_idx_1, AGE ? (N-1-k) : k);
        end
        reset = 1'b1;
        step("mid_reset");
        chk("mid_reset_outs", {grant_vld_0, grant_vld_1, grant_idx_0, grant_idx_1}, 0);
        chk("mid_reset_vecs", {grant_vec, occ_vec}, 0);
        reset = 1'b0;
        drive(0, 0, 0, 0, '0, '0, '0, 0);
        step("post_reset");

        // Randomized traffic against the reference model
        for (int c = 0; c < 1500; c++) begin
            int a1, a2;
            bit rst_now = ($urandom_range(0, 199) == 0);
            a1 = ($urandom_range(0, 1) == 1) ? pick_free(-1) : -1;
            a2 = ($urandom_range(0, 2) == 0) ? pick_free(a1)  : -1;
            drive(!rst_now && (a1 >= 0), (a1 >= 0) ? a1 : 0,
                  !rst_now && (a2 >= 0), (a2 >= 0) ? a2 : 0,
                  N'($urandom & $urandom), N'($urandom & $urandom),
                  ($urandom_range(0, 5) == 0) ? N'($urandom & $urandom & $urandom) : '0,
                  ($urandom_range(0, 7) == 0));
            reset = rst_now;
            step("rnd");
        end
        reset = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
